// File: rtl/frame_avg_accum.sv
// frame_avg_accum: coherent frame averager placed ahead of the FFT core.
// Sums 2^NAVG_LOG2 frames bin by bin and streams the average during the last frame.
`default_nettype none

module frame_avg_accum #(
  parameter int DATA_W         = 32,
  parameter int FRAME_LEN_LOG2 = 7,
  parameter int NAVG_LOG2      = 2,
  parameter int ROUND          = 1
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_clear,
  input  logic [DATA_W-1:0]                          i_data,
  input  logic                                       i_data_valid,
  output logic                                       o_data_ready,
  output logic [DATA_W-1:0]                          o_data,
  output logic                                       o_data_valid,
  input  logic                                       i_data_ready,
  output logic                                       o_last,
  output logic [FRAME_LEN_LOG2-1:0]                  o_index,
  output logic [((NAVG_LOG2 > 0) ? NAVG_LOG2 : 1)-1:0] o_frame
);

  localparam int FRAME_W = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
  localparam int ACC_W   = DATA_W + NAVG_LOG2;
  localparam int DEPTH   = 1 << FRAME_LEN_LOG2;

  localparam logic [FRAME_W-1:0]        LAST_FRAME = FRAME_W'((1 << NAVG_LOG2) - 1);
  localparam logic [FRAME_LEN_LOG2-1:0] LAST_BIN   = '1;
  // Half an LSB of the averaged result; zero when truncating or not averaging.
  localparam logic signed [ACC_W-1:0]   BIAS       =
    (ROUND != 0) ? ACC_W'((2 ** NAVG_LOG2) / 2) : '0;

  logic signed [ACC_W-1:0]   acc_mem [DEPTH];
  logic [FRAME_LEN_LOG2-1:0] index;
  logic [FRAME_W-1:0]        frame;

  logic                      out_phase;
  logic                      accept;
  logic                      handshake;
  logic signed [ACC_W-1:0]   data_ext;
  logic signed [ACC_W-1:0]   acc_rd;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   rounded;
  logic [DATA_W-1:0]         avg;

  always_comb begin
    out_phase    = (frame == LAST_FRAME);
    // Only the final frame can be blocked, and only by an undrained output.
    o_data_ready = out_phase ? (!o_data_valid || i_data_ready) : 1'b1;
    accept       = i_data_valid && o_data_ready;
    handshake    = o_data_valid && i_data_ready;
    data_ext     = ACC_W'($signed(i_data));
    // Frame 0 ignores whatever the RAM holds, so stale sums never need clearing.
    acc_rd       = (frame == '0) ? '0 : acc_mem[index];
    sum          = data_ext + acc_rd;
    rounded      = sum + BIAS;
    avg          = DATA_W'(rounded >>> NAVG_LOG2);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clear && accept && !out_phase) begin
      acc_mem[index] <= sum;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      index        <= '0;
      frame        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_last       <= 1'b0;
    end else if (i_clear) begin
      index        <= '0;
      frame        <= '0;
      o_data_valid <= 1'b0;
      o_last       <= 1'b0;
    end else begin
      if (accept) begin
        index <= index + FRAME_LEN_LOG2'(1);
        if (index == LAST_BIN) begin
          frame <= (frame == LAST_FRAME) ? '0 : frame + FRAME_W'(1);
        end
      end
      if (accept && out_phase) begin
        o_data       <= avg;
        o_data_valid <= 1'b1;
        o_last       <= (index == LAST_BIN);
      end else if (handshake) begin
        o_data_valid <= 1'b0;
        o_last       <= 1'b0;
      end
    end
  end

  assign o_index = index;
  assign o_frame = frame;

endmodule

`default_nettype wire

// File: tb/tb_frame_avg_accum.sv
// tb_frame_avg_accum: table vectors, directed corner sequences and random traffic
// checked against an arithmetic per-bin averaging model.
`default_nettype none

module tb_frame_avg_accum;

  localparam int NB = 128;
  localparam int NF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] din   = '0;
  logic [15:0] din16;
  assign din16 = din[15:0];

  logic [31:0] o_data_a, o_data_b;
  logic [15:0] o_data_c;
  logic        rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, last_a, last_b, last_c;
  logic [6:0]  idx_a, idx_b, idx_c;
  logic [1:0]  frm_a, frm_b, frm_c;

  logic        p_clear = 1'b0;
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b1;
  logic [31:0] p_din   = '0;
  logic [31:0] o_data_d;
  logic        rdy_d, ov_d, last_d;
  logic [2:0]  idx_d;
  logic [0:0]  frm_d;

  frame_avg_accum #(.DATA_W(32), .FRAME_LEN_LOG2(7), .NAVG_LOG2(2), .ROUND(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_data(din), .i_data_valid(valid),
    .o_data_ready(rdy_a), .o_data(o_data_a), .o_data_valid(ov_a), .i_data_ready(ready),
    .o_last(last_a), .o_index(idx_a), .o_frame(frm_a));

  frame_avg_accum #(.DATA_W(32), .FRAME_LEN_LOG2(7), .NAVG_LOG2(2), .ROUND(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_data(din), .i_data_valid(valid),
    .o_data_ready(rdy_b), .o_data(o_data_b), .o_data_valid(ov_b), .i_data_ready(ready),
    .o_last(last_b), .o_index(idx_b), .o_frame(frm_b));

  frame_avg_accum #(.DATA_W(16), .FRAME_LEN_LOG2(7), .NAVG_LOG2(2), .ROUND(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_data(din16), .i_data_valid(valid),
    .o_data_ready(rdy_c), .o_data(o_data_c), .o_data_valid(ov_c), .i_data_ready(ready),
    .o_last(last_c), .o_index(idx_c), .o_frame(frm_c));

  frame_avg_accum #(.DATA_W(32), .FRAME_LEN_LOG2(3), .NAVG_LOG2(0), .ROUND(1)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(p_clear), .i_data(p_din), .i_data_valid(p_valid),
    .o_data_ready(rdy_d), .o_data(o_data_d), .o_data_valid(ov_d), .i_data_ready(p_ready),
    .o_last(last_d), .o_index(idx_d), .o_frame(frm_d));

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input longint a, input longint b, input longint c,
                      input longint e);
    chk({name, "_a"}, a, e);
    chk({name, "_b"}, b, e);
    chk({name, "_c"}, c, e);
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Reference model: per-bin running totals and a queue of expected averages.
  typedef struct packed {
    logic signed [63:0] e0;
    logic signed [63:0] e1;
    logic signed [63:0] e2;
    logic               last;
  } exp_t;
  typedef struct packed {
    logic signed [63:0] d;
    logic               last;
  } expd_t;

  exp_t   q[$];
  expd_t  qd[$];
  longint ms32 [NB];
  longint ms16 [NB];
  int     midx = 0, mframe = 0, midx_d = 0;
  bit     accepted = 1'b0;
  int     nout = 0, nrdylow = 0;
  longint lastout_a = 0, lastout_b = 0, lastout_c = 0;
  bit     done = 1'b0;

  always @(negedge clk) begin
    bit     exp_rdy, acc;
    longint v32, v16, s32, s16;
    exp_t   e;
    expd_t  ed;
    accepted = 1'b0;
    if (!rst_n || clear) begin
      midx = 0;
      mframe = 0;
      q.delete();
    end else begin
      exp_rdy = !(mframe == NF - 1 && q.size() != 0 && !ready);
      chk3("index", idx_a, idx_b, idx_c, midx);
      chk3("frame", frm_a, frm_b, frm_c, mframe);
      chk3("valid", ov_a, ov_b, ov_c, longint'(q.size() != 0));
      chk3("ready", rdy_a, rdy_b, rdy_c, longint'(exp_rdy));
      if (!rdy_a) nrdylow++;
      if (q.size() != 0) begin
        chk("data_a", $signed(o_data_a), q[0].e0);
        chk("data_b", $signed(o_data_b), q[0].e1);
        chk("data_c", $signed(o_data_c), q[0].e2);
        chk3("last", last_a, last_b, last_c, longint'(q[0].last));
        if (ready) begin
          lastout_a = $signed(o_data_a);
          lastout_b = $signed(o_data_b);
          lastout_c = $signed(o_data_c);
          nout++;
          void'(q.pop_front());
        end
      end
      acc = valid && exp_rdy;
      accepted = acc;
      if (acc) begin
        v32 = $signed(din);
        v16 = $signed(din16);
        s32 = (mframe == 0) ? v32 : ms32[midx] + v32;
        s16 = (mframe == 0) ? v16 : ms16[midx] + v16;
        if (mframe != NF - 1) begin
          ms32[midx] = s32;
          ms16[midx] = s16;
        end else begin
          e.e0   = fdiv(s32 + 2, NF);
          e.e1   = fdiv(s32, NF);
          e.e2   = fdiv(s16 + 2, NF);
          e.last = (midx == NB - 1);
          q.push_back(e);
        end
        midx = (midx + 1) % NB;
        if (midx == 0) mframe = (mframe + 1) % NF;
      end
    end

    // Passthrough instance: each accepted sample reappears unchanged one cycle later.
    if (!rst_n) begin
      midx_d = 0;
      qd.delete();
    end else begin
      chk("index_d", idx_d, midx_d);
      chk("frame_d", frm_d, 0);
      chk("valid_d", ov_d, longint'(qd.size() != 0));
      chk("ready_d", rdy_d, longint'(!(qd.size() != 0 && !p_ready)));
      if (qd.size() != 0) begin
        chk("data_d", $signed(o_data_d), qd[0].d);
        chk("last_d", last_d, longint'(qd[0].last));
        if (p_ready) void'(qd.pop_front());
      end
      if (p_valid && !(qd.size() != 0 && !p_ready)) begin
        ed.d    = $signed(p_din);
        ed.last = (midx_d == 7);
        qd.push_back(ed);
        midx_d  = (midx_d + 1) % 8;
      end
    end
  end

  typedef struct {
    int f0, f1, f2, f3;
    int r1, r0;
  } vec_t;
  vec_t tbl [10];
  int   pat [4];
  int   tpat [4] = '{1, 0, 0, 1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: per-frame constant pat[], 1: ramp = bin index, 2: random samples
  task automatic run_n(input int mode, input int count, input bit tog);
    int n = 0;
    int cyc = 0;
    while (n < count && cyc < 4 * count + 16) begin
      case (mode)
        0:       din = pat[(n / NB) % NF];
        1:       din = n % NB;
        default: din = $urandom;
      endcase
      valid = 1'b1;
      ready = tog ? tpat[cyc % 4][0] : 1'b1;
      @(posedge clk);
      if (accepted) n++;
      cyc++;
      #1;
    end
    chk("accepts_done", n, count);
  endtask

  task automatic drain();
    valid = 1'b0;
    ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic check_seq(input string name, input longint ea, input longint eb,
                           input longint ec);
    chk({name, "_outputs"}, nout, NB);
    chk({name, "_avg_a"}, lastout_a, ea);
    chk({name, "_avg_b"}, lastout_b, eb);
    chk({name, "_avg_c"}, lastout_c, ec);
  endtask

  initial begin
    p_din = '0;
    wait (rst_n);
    while (!done) begin
      p_din   = $urandom;
      p_valid = ($urandom_range(0, 2) != 0);
      p_ready = ($urandom_range(0, 3) != 0);
      step();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, 1, 0, 1, 0};
    tbl[1] = '{-2, -1, 0, 0, -1, -1};
    tbl[2] = '{5, 6, 7, 9, 7, 6};
    tbl[3] = '{-5, -6, -7, -9, -7, -7};
    tbl[4] = '{-1, 0, 0, 0, 0, -1};
    tbl[5] = '{2, 0, 0, 0, 1, 0};
    tbl[6] = '{-2, 0, 0, 0, 0, -1};
    tbl[7] = '{32767, 32767, 32767, 32767, 32767, 32767};
    tbl[8] = '{-32768, -32768, -32768, -32768, -32768, -32768};
    tbl[9] = '{32767, -32768, 32767, -32768, 0, -1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk3("rst_data", o_data_a, o_data_b, o_data_c, 0);
    chk3("rst_valid", ov_a, ov_b, ov_c, 0);
    chk3("rst_last", last_a, last_b, last_c, 0);
    chk3("rst_index", idx_a, idx_b, idx_c, 0);
    chk3("rst_frame", frm_a, frm_b, frm_c, 0);
    chk("rst_data_d", o_data_d, 0);
    chk("rst_valid_d", ov_d, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    pat = '{100, 100, 100, 100};
    nout = 0;
    run_n(0, NB * NF, 1'b0);
    drain();
    check_seq("const100", 100, 100, 100);
    chk("const100_frame", frm_a, 0);

    for (int i = 0; i < 10; i++) begin
      pat = '{tbl[i].f0, tbl[i].f1, tbl[i].f2, tbl[i].f3};
      nout = 0;
      run_n(0, NB * NF, 1'b0);
      drain();
      check_seq($sformatf("tbl%0d", i), tbl[i].r1, tbl[i].r0, tbl[i].r1);
    end

    nout = 0;
    nrdylow = 0;
    run_n(1, NB * NF, 1'b1);
    drain();
    check_seq("ramp", 127, 127, 127);
    chk("ramp_stalled", longint'(nrdylow > 0), 1);

    run_n(2, 2 * NB + 50, 1'b0);
    clear = 1'b1;
    din   = $urandom;
    step();
    clear = 1'b0;
    pat   = '{7, 7, 7, 7};
    nout  = 0;
    run_n(0, NB * NF, 1'b0);
    drain();
    check_seq("clear", 7, 7, 7);

    run_n(2, 3 * NB + 30, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    nout  = 0;
    run_n(0, NB * NF, 1'b0);
    drain();
    check_seq("midreset", 7, 7, 7);

    repeat (3000) begin
      din   = $urandom;
      valid = ($urandom_range(0, 9) < 7);
      ready = ($urandom_range(0, 9) < 7);
      clear = ($urandom_range(0, 299) == 0);
      step();
    end
    clear = 1'b0;
    drain();

    done = 1'b1;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

`default_nettype wire
